// File: rtl/timing_gen.sv
// 4004-style timing generator: two-phase clk1/clk2 enables, one-hot subcycle strobes, SYNC/EOC.
// Optional single-step HOLD state when TIMING_STEP_EN is defined.
module timing_gen #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic       sysclk,
    input  logic       poc,
`ifdef TIMING_STEP_EN
    input  logic       run,
    input  logic       step,
`endif
    output logic       clk1,
    output logic       clk2,
    output logic       a12,
    output logic       a22,
    output logic       a32,
    output logic       m12,
    output logic       m22,
    output logic       x12,
    output logic       x22,
    output logic       x32,
    output logic       sync,
    output logic [2:0] subcycle,
    output logic       eoc
);

    localparam int unsigned TickW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [TickW-1:0] TickLast = TickW'(CLK_DIV - 1);

    typedef enum logic [0:0] {StRun, StHold} mode_e;

    mode_e            mode_q, mode_d;
    logic [TickW-1:0] tick_q, tick_d;
    logic [1:0]       slot_q, slot_d;
    logic [2:0]       sub_q, sub_d;

    logic       clk1_d, clk2_d, sync_d, eoc_d;
    logic [7:0] strb_d;
    logic [2:0] subcycle_d;
    logic       hold_req;

`ifdef TIMING_STEP_EN
    // eoc marks the final tick; the reset-loaded end state never asserts it, so
    // the first cycle after poc always runs.
    assign hold_req = eoc & ~run;
`else
    assign hold_req = 1'b0;
`endif

    // State register
    always_ff @(posedge sysclk) begin
        if (poc) begin
            mode_q <= StRun;
            tick_q <= TickLast;
            slot_q <= 2'd3;
            sub_q  <= 3'd7;
        end else begin
            mode_q <= mode_d;
            tick_q <= tick_d;
            slot_q <= slot_d;
            sub_q  <= sub_d;
        end
    end

    // Next-state: ripple tick -> slot -> subcycle, with optional HOLD at cycle end
    always_comb begin
        mode_d = mode_q;
        tick_d = tick_q;
        slot_d = slot_q;
        sub_d  = sub_q;
        unique case (mode_q)
            StHold: begin
`ifdef TIMING_STEP_EN
                if (step || run) begin
                    mode_d = StRun;
                    tick_d = '0;
                    slot_d = 2'd0;
                    sub_d  = 3'd0;
                end
`endif
            end
            default: begin
                if (hold_req) begin
                    mode_d = StHold;
                end else if (tick_q == TickLast) begin
                    tick_d = '0;
                    slot_d = slot_q + 2'd1;
                    if (slot_q == 2'd3) begin
                        sub_d = sub_q + 3'd1;
                    end
                end else begin
                    tick_d = tick_q + TickW'(1);
                end
            end
        endcase
    end

    // Output decode from the next state so every output is registered
    always_comb begin
        clk1_d     = 1'b0;
        clk2_d     = 1'b0;
        strb_d     = 8'h00;
        sync_d     = 1'b0;
        eoc_d      = 1'b0;
        subcycle_d = 3'd0;
        if (!poc) begin
            if (mode_d == StHold) begin
                subcycle_d = 3'd7;
            end else begin
                clk1_d     = (slot_d == 2'd0);
                clk2_d     = (slot_d == 2'd2);
                strb_d     = 8'h01 << sub_d;
                sync_d     = (sub_d == 3'd7);
                eoc_d      = (sub_d == 3'd7) && (slot_d == 2'd3) && (tick_d == TickLast);
                subcycle_d = sub_d;
            end
        end
    end

    always_ff @(posedge sysclk) begin
        clk1     <= clk1_d;
        clk2     <= clk2_d;
        a12      <= strb_d[0];
        a22      <= strb_d[1];
        a32      <= strb_d[2];
        m12      <= strb_d[3];
        m22      <= strb_d[4];
        x12      <= strb_d[5];
        x22      <= strb_d[6];
        x32      <= strb_d[7];
        sync     <= sync_d;
        eoc      <= eoc_d;
        subcycle <= subcycle_d;
    end

endmodule

// File: tb/tb_timing_gen.sv
// Randomized self-checking bench for timing_gen at CLK_DIV=2 and CLK_DIV=1 against a
// position-in-cycle reference model; HOLD scenarios run when TIMING_STEP_EN is defined.
module tb_timing_gen;

    logic sysclk = 1'b0;
    logic poc    = 1'b1;
    logic run_s  = 1'b1;
    logic step_s = 1'b0;

    always #5 sysclk = ~sysclk;

    logic       c1_a, c2_a, sy_a, eo_a, c1_b, c2_b, sy_b, eo_b;
    logic [7:0] st_a, st_b;
    logic [2:0] sc_a, sc_b;

    timing_gen #(.CLK_DIV(2)) u_div2 (
        .sysclk(sysclk), .poc(poc),
`ifdef TIMING_STEP_EN
        .run(run_s), .step(step_s),
`endif
        .clk1(c1_a), .clk2(c2_a),
        .a12(st_a[0]), .a22(st_a[1]), .a32(st_a[2]), .m12(st_a[3]),
        .m22(st_a[4]), .x12(st_a[5]), .x22(st_a[6]), .x32(st_a[7]),
        .sync(sy_a), .subcycle(sc_a), .eoc(eo_a)
    );

    timing_gen #(.CLK_DIV(1)) u_div1 (
        .sysclk(sysclk), .poc(poc),
`ifdef TIMING_STEP_EN
        .run(run_s), .step(step_s),
`endif
        .clk1(c1_b), .clk2(c2_b),
        .a12(st_b[0]), .a22(st_b[1]), .a32(st_b[2]), .m12(st_b[3]),
        .m22(st_b[4]), .x12(st_b[5]), .x22(st_b[6]), .x32(st_b[7]),
        .sync(sy_b), .subcycle(sc_b), .eoc(eo_b)
    );

    int errors = 0;
    int checks = 0;

    // Model: ticks since start of A1, plus reset/hold flags
    int div [2] = '{2, 1};
    int pos [2];
    bit in_rst [2] = '{1'b1, 1'b1};
    bit in_hold [2] = '{1'b0, 1'b0};

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input int k);
        int last;
        last = 32 * div[k] - 1;
        if (poc) begin
            in_rst[k]  = 1'b1;
            in_hold[k] = 1'b0;
        end else if (in_rst[k]) begin
            in_rst[k] = 1'b0;
            pos[k]    = 0;
        end else if (in_hold[k]) begin
            if (step_s || run_s) begin
                in_hold[k] = 1'b0;
                pos[k]     = 0;
            end
        end else if (pos[k] == last) begin
`ifdef TIMING_STEP_EN
            if (!run_s) in_hold[k] = 1'b1;
            else pos[k] = 0;
`else
            pos[k] = 0;
`endif
        end else begin
            pos[k]++;
        end
    endtask

    task automatic compare(input int k, input logic c1, input logic c2, input logic [7:0] st,
                           input logic sy, input logic [2:0] sc, input logic eo);
        int sub, slot;
        logic [7:0] e_st;
        logic e_c1, e_c2, e_sy, e_eo;
        logic [2:0] e_sc;
        string tag;
        tag = (k == 0) ? "div2" : "div1";
        e_st = 8'h00; e_c1 = 1'b0; e_c2 = 1'b0; e_sy = 1'b0; e_eo = 1'b0; e_sc = 3'd0;
        if (in_hold[k]) begin
            e_sc = 3'd7;
        end else if (!in_rst[k]) begin
            sub  = pos[k] / (4 * div[k]);
            slot = (pos[k] / div[k]) % 4;
            e_c1 = (slot == 0);
            e_c2 = (slot == 2);
            e_st = 8'h01 << sub;
            e_sy = (sub == 7);
            e_eo = (pos[k] == 32 * div[k] - 1);
            e_sc = 3'(sub);
        end
        check({tag, " clk1"}, 8'(c1), 8'(e_c1));
        check({tag, " clk2"}, 8'(c2), 8'(e_c2));
        check({tag, " strobes"}, st, e_st);
        check({tag, " sync"}, 8'(sy), 8'(e_sy));
        check({tag, " subcycle"}, 8'(sc), 8'(e_sc));
        check({tag, " eoc"}, 8'(eo), 8'(e_eo));
        check({tag, " clk overlap"}, 8'(c1 & c2), 8'h00);
        check({tag, " sync==x32"}, 8'(sy), 8'(st[7]));
    endtask

    task automatic tick();
        @(posedge sysclk);
        model_step(0);
        model_step(1);
        #1;
        compare(0, c1_a, c2_a, st_a, sy_a, sc_a, eo_a);
        compare(1, c1_b, c2_b, st_b, sy_b, sc_b, eo_b);
    endtask

    initial begin
        int last_eoc;
        int n;
        bit found;

        // Power-on clear, then three free-running cycles
        poc = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        poc = 1'b0;
        last_eoc = -1;
        for (int t = 0; t < 200; t++) begin
            tick();
            if (t == 0) begin
                check("release clk1", 8'(c1_a), 8'h01);
                check("release a12", 8'(st_a[0]), 8'h01);
                check("release subcycle", 8'(sc_a), 8'h00);
                check("release div1 clk1", 8'(c1_b), 8'h01);
            end
            if (t == 3) check("clk2 before", 8'(c2_a), 8'h00);
            if (t == 4) check("clk2 rise", 8'(c2_a), 8'h01);
            if (t == 7) check("a22 before", 8'(st_a[1]), 8'h00);
            if (t == 8) check("a22 rise", 8'(st_a[1]), 8'h01);
            if (t == 2) check("div1 clk2 slot2", 8'(c2_b), 8'h01);
            if (eo_a) begin
                if (last_eoc >= 0) check("eoc period", 8'(t - last_eoc), 8'd64);
                last_eoc = t;
            end
        end

        // poc during M2 slot 2 aborts the cycle
        found = 1'b0;
        for (int i = 0; i < 80 && !found; i++) begin
            tick();
            if (sc_a == 3'd4 && c2_a) found = 1'b1;
        end
        check("reach m22 slot2", 8'(found), 8'h01);
        poc = 1'b1;
        tick();
        check("abort all zero", {c1_a, c2_a, sy_a, eo_a, 4'h0} | st_a, 8'h00);
        poc = 1'b0;
        tick();
        check("restart clk1", 8'(c1_a), 8'h01);
        check("restart a12", 8'(st_a[0]), 8'h01);
        for (int i = 0; i < 40; i++) tick();

`ifdef TIMING_STEP_EN
        // Drop run: finish the current cycle then sit in HOLD
        run_s = 1'b0;
        n = 0;
        while (!in_hold[0] && n < 200) begin
            tick();
            n++;
        end
        check("enter hold", 8'(in_hold[0]), 8'h01);
        for (int i = 0; i < 20; i++) begin
            tick();
            check("hold subcycle", 8'(sc_a), 8'h07);
            check("hold clk1", 8'(c1_a), 8'h00);
        end
        // One step = one cycle; a second step mid-cycle is ignored
        step_s = 1'b1;
        tick();
        step_s = 1'b0;
        check("step clk1", 8'(c1_a), 8'h01);
        n = 0;
        found = 1'b0;
        while (!found && n < 100) begin
            if (n == 10) step_s = 1'b1;
            tick();
            step_s = 1'b0;
            n++;
            if (eo_a) found = 1'b1;
        end
        check("step cycle length", 8'(n), 8'd63);
        tick();
        check("rehold subcycle", 8'(sc_a), 8'h07);
        check("rehold clk1", 8'(c1_a), 8'h00);
        for (int i = 0; i < 5; i++) tick();
        run_s = 1'b1;
        tick();
        check("run resume clk1", 8'(c1_a), 8'h01);
        check("run resume a12", 8'(st_a[0]), 8'h01);
        for (int i = 0; i < 150; i++) tick();
`endif

        // Random poc/step/run traffic
        for (int i = 0; i < 4000; i++) begin
            poc = ($urandom_range(0, 199) == 0);
`ifdef TIMING_STEP_EN
            step_s = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 99) == 0) run_s = ~run_s;
`endif
            tick();
        end
        poc = 1'b0;
        for (int i = 0; i < 70; i++) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
